// File: rtl/red_pitaya_dac_slew.sv
// Per-channel DAC output conditioner: ramps between a park level and the live
// ASG waveform, slew-limits the tracked signal and counts limited cycles.
module red_pitaya_dac_slew #(
  parameter int DW = 14,
  parameter int CW = 16
) (
  input  logic          dac_clk_i,
  input  logic          dac_rstn_i,
  input  logic [DW-1:0] dat_i,
  input  logic          set_en_i,
  input  logic          set_mute_i,
  input  logic [DW-1:0] set_slew_i,
  input  logic [DW-1:0] set_park_i,
  input  logic          clr_i,
  output logic [DW-1:0] dac_o,
  output logic [1:0]    state_o,
  output logic          settled_o,
  output logic [CW-1:0] clip_cnt_o
);

  typedef enum logic [1:0] {
    ST_PARK     = 2'd0,
    ST_RAMP_IN  = 2'd1,
    ST_TRACK    = 2'd2,
    ST_RAMP_OUT = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] dat_r_q, dat_r_d;
  logic [DW-1:0] dac_q, dac_d;
  logic          settled_q, settled_d;
  logic [CW-1:0] clip_q, clip_d;

  logic [DW-1:0] target;
  logic [DW:0]   diff;
  logic [DW:0]   mag;
  logic          limited;
  logic [DW-1:0] stepped;
  logic          clip_inc;

  // Slew step toward the current state's target; the difference is taken one
  // bit wider so any pair of DW-bit values compares without overflow.
  always_comb begin
    target  = (state_q == ST_RAMP_OUT) ? set_park_i : dat_r_q;
    diff    = {target[DW-1], target} - {dac_q[DW-1], dac_q};
    mag     = diff[DW] ? (~diff + 1'b1) : diff;
    limited = (set_slew_i != '0) && (mag > {1'b0, set_slew_i});
    if (limited) begin
      stepped = diff[DW] ? (dac_q - set_slew_i) : (dac_q + set_slew_i);
    end else begin
      stepped = target;
    end
  end

  // Next-state, output sample and clip counter; mute overrides every state.
  always_comb begin
    dat_r_d  = dat_i;
    state_d  = state_q;
    dac_d    = dac_q;
    clip_inc = 1'b0;
    if (set_mute_i) begin
      dac_d   = set_park_i;
      state_d = ST_PARK;
    end else begin
      unique case (state_q)
        ST_PARK: begin
          dac_d = set_park_i;
          if (set_en_i) state_d = ST_RAMP_IN;
        end
        ST_RAMP_IN: begin
          dac_d = stepped;
          if (!set_en_i)     state_d = ST_RAMP_OUT;
          else if (!limited) state_d = ST_TRACK;
        end
        ST_TRACK: begin
          dac_d    = stepped;
          clip_inc = limited;
          if (!set_en_i) state_d = ST_RAMP_OUT;
        end
        ST_RAMP_OUT: begin
          dac_d = stepped;
          if (set_en_i)      state_d = ST_RAMP_IN;
          else if (!limited) state_d = ST_PARK;
        end
        default: state_d = ST_PARK;
      endcase
    end
    settled_d = !set_mute_i && (state_d == ST_TRACK) && !limited;
    if (clr_i) begin
      clip_d = '0;
    end else if (clip_inc && (clip_q != '1)) begin
      clip_d = clip_q + 1'b1;
    end else begin
      clip_d = clip_q;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge dac_clk_i) begin
    if (!dac_rstn_i) begin
      state_q   <= ST_PARK;
      dat_r_q   <= '0;
      dac_q     <= '0;
      settled_q <= 1'b0;
      clip_q    <= '0;
    end else begin
      state_q   <= state_d;
      dat_r_q   <= dat_r_d;
      dac_q     <= dac_d;
      settled_q <= settled_d;
      clip_q    <= clip_d;
    end
  end

  assign dac_o      = dac_q;
  assign state_o    = state_q;
  assign settled_o  = settled_q;
  assign clip_cnt_o = clip_q;

endmodule

// File: tb/tb_red_pitaya_dac_slew.sv
// Directed bench for red_pitaya_dac_slew with hand-computed expectations.
module tb_red_pitaya_dac_slew;

  localparam int DW = 14;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic [DW-1:0] dat;
  logic          en, mute, clr;
  logic [DW-1:0] slew, park;
  logic [DW-1:0] dac;
  logic [1:0]    state;
  logic          settled;
  logic [CW-1:0] clip;

  int n_checks = 0;
  int n_pass   = 0;

  red_pitaya_dac_slew #(.DW(DW), .CW(CW)) dut (
    .dac_clk_i  (clk),
    .dac_rstn_i (rstn),
    .dat_i      (dat),
    .set_en_i   (en),
    .set_mute_i (mute),
    .set_slew_i (slew),
    .set_park_i (park),
    .clr_i      (clr),
    .dac_o      (dac),
    .state_o    (state),
    .settled_o  (settled),
    .clip_cnt_o (clip)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int sdac();
    return int'($signed(dac));
  endfunction

  initial begin
    rstn = 1'b0; dat = 14'd1000; en = 1'b0; mute = 1'b0; clr = 1'b0;
    slew = '0; park = '0;
    tick(); tick();
    chk("rst_dac", sdac(), 0);
    chk("rst_state", int'(state), 0);
    chk("rst_settled", int'(settled), 0);
    chk("rst_clip", int'(clip), 0);

    // 1: bypass slew, enable -> RAMP_IN -> TRACK with dac=1000
    rstn = 1'b1;
    tick();
    chk("t1_park_state", int'(state), 0);
    en = 1'b1;
    tick();
    chk("t1_ramp_in", int'(state), 1);
    chk("t1_ramp_in_dac", sdac(), 0);
    tick();
    chk("t1_track", int'(state), 2);
    chk("t1_dac", sdac(), 1000);
    chk("t1_settled", int'(settled), 1);
    chk("t1_clip", int'(clip), 0);

    // 2: step 0 -> 1000 at slew 100
    dat = '0;
    tick(); tick();
    chk("t2_dac0", sdac(), 0);
    slew = 14'd100; dat = 14'd1000;
    tick();
    chk("t2_lat", sdac(), 0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("t2_dac_%0d", k), sdac(), 100 * k);
      chk($sformatf("t2_settled_%0d", k), int'(settled), (k == 10) ? 1 : 0);
    end
    chk("t2_clip", int'(clip), 9);

    // 3: ramp out from 5000 to park 0 at slew 1000
    slew = '0; dat = 14'd5000;
    tick(); tick();
    chk("t3_dac5000", sdac(), 5000);
    slew = 14'd1000; en = 1'b0;
    tick();
    chk("t3_ro_state", int'(state), 3);
    chk("t3_ro_dac", sdac(), 5000);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("t3_dac_%0d", k), sdac(), 5000 - 1000 * k);
      chk($sformatf("t3_state_%0d", k), int'(state), (k < 5) ? 3 : 0);
    end
    chk("t3_clip", int'(clip), 9);

    // 4: extreme -8192 -> 8191 at slew 8191, no wrap
    park = 14'h2000;
    tick();
    chk("t4_park", sdac(), -8192);
    dat = 14'h1FFF; slew = 14'h1FFF; en = 1'b1;
    tick();
    chk("t4_ri", int'(state), 1);
    tick();
    chk("t4_dac_a", sdac(), -1);
    tick();
    chk("t4_dac_b", sdac(), 8190);
    chk("t4_state_b", int'(state), 1);
    tick();
    chk("t4_dac_c", sdac(), 8191);
    chk("t4_state_c", int'(state), 2);

    // 5: mute during RAMP_OUT
    park = '0; slew = '0; dat = 14'd3000;
    tick(); tick();
    chk("t5_dac3000", sdac(), 3000);
    slew = 14'd1000; en = 1'b0;
    tick();
    chk("t5_ro", int'(state), 3);
    mute = 1'b1; park = 14'd500;
    tick();
    chk("t5_mute_dac", sdac(), 500);
    chk("t5_mute_state", int'(state), 0);
    chk("t5_mute_settled", int'(settled), 0);
    en = 1'b1;
    tick();
    chk("t5_mute_hold", int'(state), 0);
    mute = 1'b0;
    tick();
    chk("t5_unmute", int'(state), 1);

    // 6: clip counter saturation, clear priority, reset mid-ramp
    slew = '0;
    tick();
    chk("t6_track", int'(state), 2);
    chk("t6_dac", sdac(), 3000);
    slew = 14'd1; dat = 14'd8000; clr = 1'b1;
    tick();
    chk("t6_clr0", int'(clip), 0);
    clr = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    chk("t6_sat", int'(clip), 15);
    chk("t6_dac_lim", sdac(), 3020);
    chk("t6_sat_settled", int'(settled), 0);
    clr = 1'b1;
    tick();
    chk("t6_clr_wins", int'(clip), 0);
    clr = 1'b0;
    tick();
    chk("t6_inc", int'(clip), 1);
    en = 1'b0;
    tick();
    chk("t6_ro", int'(state), 3);
    en = 1'b1;
    tick();
    chk("t6_ri", int'(state), 1);
    chk("t6_ri_dac", sdac(), 3022);
    rstn = 1'b0;
    tick();
    chk("t6_rst_dac", sdac(), 0);
    chk("t6_rst_state", int'(state), 0);
    chk("t6_rst_clip", int'(clip), 0);
    chk("t6_rst_settled", int'(settled), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
